// File: rtl/jk_cmd_seq.sv
// Command sequencer for a W-bit JK flip-flop bank: drives J/K per command,
// reads back Q and flags any bit that did not reach the expected state.
module jk_cmd_seq #(
    parameter int unsigned W  = 4,
    parameter int unsigned RW = 4
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_mask,
    input  logic [RW-1:0] cmd_rep,
    output logic [W-1:0]  J,
    output logic [W-1:0]  K,
    input  logic [W-1:0]  Q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  err_bits
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_HOLD   = 2'd0;
    localparam logic [1:0] OP_RESET  = 2'd1;
    localparam logic [1:0] OP_SET    = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    state_t        state;
    logic [1:0]    op_r;
    logic [W-1:0]  mask_r;
    logic [RW-1:0] rem;
    logic [W-1:0]  exp_q;

    // op encoding: bit1 drives J (SET/TOGGLE), bit0 drives K (RESET/TOGGLE)
    function automatic logic [W-1:0] drive_j(input logic [1:0] op, input logic [W-1:0] m);
        return op[1] ? m : '0;
    endfunction

    function automatic logic [W-1:0] drive_k(input logic [1:0] op, input logic [W-1:0] m);
        return op[0] ? m : '0;
    endfunction

    function automatic logic [W-1:0] next_q(input logic [1:0] op, input logic [W-1:0] m,
                                             input logic [W-1:0] q);
        logic [W-1:0] r;
        case (op)
            OP_HOLD:   r = q;
            OP_RESET:  r = q & ~m;
            OP_SET:    r = q | m;
            OP_TOGGLE: r = q ^ m;
            default:   r = q;
        endcase
        return r;
    endfunction

    // Ready only while idle and out of reset, so it reads low throughout reset.
    assign cmd_ready = rst & (state == IDLE);

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_r     <= OP_HOLD;
            mask_r   <= '0;
            rem      <= '0;
            exp_q    <= '0;
            J        <= '0;
            K        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_bits <= '0;
        end else begin
            J    <= '0;
            K    <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r     <= cmd_op;
                        mask_r   <= cmd_mask;
                        rem      <= cmd_rep;
                        err      <= 1'b0;
                        err_bits <= '0;
                        J        <= drive_j(cmd_op, cmd_mask);
                        K        <= drive_k(cmd_op, cmd_mask);
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Q here is still the pre-edge bank state.
                    exp_q <= next_q(op_r, mask_r, Q);
                    state <= CHECK;
                end
                CHECK: begin
                    if (Q != exp_q) begin
                        err      <= 1'b1;
                        err_bits <= err_bits | (Q ^ exp_q);
                    end
                    if (rem != '0) begin
                        rem   <= rem - RW'(1);
                        J     <= drive_j(op_r, mask_r);
                        K     <= drive_k(op_r, mask_r);
                        state <= DRIVE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: behavioural JK bank with stuck-at-0 injection,
// command table with per-cycle checks and a completion scoreboard.
module tb_jk_cmd_seq;

    logic       Clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [3:0] cmd_rep;
    logic [3:0] J, K, Q;
    logic       busy, done, err;
    logic [3:0] err_bits;

    logic [3:0] q_bank;
    logic [3:0] stuck;
    logic       bank_load;
    logic [3:0] bank_load_val;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    typedef struct {
        logic [3:0] q;
        logic       e;
        logic [3:0] bits;
    } exp_t;

    typedef struct {
        logic [3:0] q0;
        logic [3:0] stk;
        logic [1:0] op;
        logic [3:0] mask;
        logic [3:0] rep;
        logic [3:0] exp_q;
        logic       exp_err;
        logic [3:0] exp_bits;
    } vec_t;

    exp_t sb[$];

    jk_cmd_seq #(.W(4), .RW(4)) dut (
        .Clk(Clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rep(cmd_rep),
        .J(J), .K(K), .Q(Q),
        .busy(busy), .done(done), .err(err), .err_bits(err_bits)
    );

    always #5 Clk = ~Clk;

    // JK bank on the same clock; stuck bits always read as 0
    always @(posedge Clk) begin
        if (bank_load) q_bank <= bank_load_val;
        else begin
            for (int b = 0; b < 4; b++) begin
                case ({J[b], K[b]})
                    2'b01:   q_bank[b] <= 1'b0;
                    2'b10:   q_bank[b] <= 1'b1;
                    2'b11:   q_bank[b] <= ~Q[b];
                    default: q_bank[b] <= Q[b];
                endcase
            end
        end
    end
    assign Q = q_bank & ~stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: each done pulse consumes one expected completion
    always @(negedge Clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_done: got done with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_q", 32'(Q), 32'(e.q));
                check("sb_err", 32'(err), 32'(e.e));
                check("sb_err_bits", 32'(err_bits), 32'(e.bits));
            end
        end
    end

    task automatic load_bank(input logic [3:0] v, input logic [3:0] s);
        @(negedge Clk);
        bank_load_val = v;
        stuck = s;
        bank_load = 1'b1;
        @(posedge Clk);
        #1 bank_load = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge Clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic exp_jk(input logic [1:0] op, input logic [3:0] m,
                          output logic [3:0] ej, output logic [3:0] ek);
        case (op)
            2'd0:    begin ej = 4'h0; ek = 4'h0; end
            2'd1:    begin ej = 4'h0; ek = m;    end
            2'd2:    begin ej = m;    ek = 4'h0; end
            default: begin ej = m;    ek = m;    end
        endcase
    endtask

    // Issue one command and check every cycle up to and including DONE
    task automatic run_cmd(input vec_t v);
        logic [3:0] ej, ek;
        int last;
        exp_t e;
        exp_jk(v.op, v.mask, ej, ek);
        last = 2 * (int'(v.rep) + 1) + 1;
        wait_ready();
        cmd_op = v.op; cmd_mask = v.mask; cmd_rep = v.rep; cmd_valid = 1'b1;
        @(posedge Clk);
        e.q = v.exp_q; e.e = v.exp_err; e.bits = v.exp_bits;
        sb.push_back(e);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                check("err_cleared", 32'(err), 32'd0);
                check("err_bits_cleared", 32'(err_bits), 32'd0);
            end
            if (c == last) begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
                check("done_ready", 32'(cmd_ready), 32'd0);
            end else if (c % 2 == 1) begin
                check("drive_j", 32'(J), 32'(ej));
                check("drive_k", 32'(K), 32'(ek));
                check("drive_busy_done", 32'({busy, done}), 32'b10);
            end else begin
                check("check_jk_zero", 32'({J, K}), 32'd0);
                check("check_busy_done", 32'({busy, done, cmd_ready}), 32'b100);
            end
        end
        @(negedge Clk);
        check("post_done_low", 32'({done, cmd_ready}), 32'b01);
    endtask

    initial begin
        vec_t vecs[7];
        exp_t e;
        int dc;
        // q0, stuck, op, mask, rep, exp_q, exp_err, exp_bits
        vecs[0] = '{4'b0000, 4'b0000, 2'd2, 4'b0101, 4'd0,  4'b0101, 1'b0, 4'b0000};
        vecs[1] = '{4'b0101, 4'b0000, 2'd3, 4'b1111, 4'd2,  4'b1010, 1'b0, 4'b0000};
        vecs[2] = '{4'b0000, 4'b0001, 2'd2, 4'b0011, 4'd0,  4'b0010, 1'b1, 4'b0001};
        vecs[3] = '{4'b1111, 4'b0000, 2'd0, 4'b1111, 4'd0,  4'b1111, 1'b0, 4'b0000};
        vecs[4] = '{4'b1111, 4'b0000, 2'd1, 4'b0110, 4'd1,  4'b1001, 1'b0, 4'b0000};
        vecs[5] = '{4'b0000, 4'b0000, 2'd3, 4'b0001, 4'd15, 4'b0000, 1'b0, 4'b0000};
        vecs[6] = '{4'b1010, 4'b0010, 2'd0, 4'b0101, 4'd1,  4'b1000, 1'b0, 4'b0000};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mask = 4'h0; cmd_rep = 4'h0;
        stuck = 4'h0; bank_load = 1'b1; bank_load_val = 4'h0;
        repeat (2) @(negedge Clk);
        check("reset_outputs", 32'({J, K, busy, done, err, err_bits}), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd0);
        bank_load = 1'b0;
        rst = 1'b1;
        @(negedge Clk);
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            load_bank(vecs[i].q0, vecs[i].stk);
            run_cmd(vecs[i]);
        end

        // Back-to-back: cmd_valid held high across two commands
        load_bank(4'b0000, 4'b0000);
        wait_ready();
        dc = done_count;
        cmd_op = 2'd2; cmd_mask = 4'b0001; cmd_rep = 4'd0; cmd_valid = 1'b1;
        @(posedge Clk);
        e.q = 4'b0001; e.e = 1'b0; e.bits = 4'b0000;
        sb.push_back(e);
        #1 cmd_op = 2'd3; cmd_mask = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clk);
            check("b2b_ready_low", 32'(cmd_ready), 32'd0);
        end
        @(negedge Clk);
        check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge Clk);
        e.q = 4'b0010; e.e = 1'b0; e.bits = 4'b0000;
        sb.push_back(e);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clk);
            check("b2b2_ready_low", 32'(cmd_ready), 32'd0);
            check("b2b2_done", 32'(done), (c == 3) ? 32'd1 : 32'd0);
        end
        @(negedge Clk);
        check("b2b_done_count", 32'(done_count - dc), 32'd2);

        // Async reset in the middle of a DRIVE cycle
        load_bank(4'b0000, 4'b0000);
        wait_ready();
        dc = done_count;
        cmd_op = 2'd3; cmd_mask = 4'b1111; cmd_rep = 4'd3; cmd_valid = 1'b1;
        @(posedge Clk);
        #1 cmd_valid = 1'b0;
        @(negedge Clk);
        check("abort_drive_jk", 32'({J, K}), 32'hFF);
        #1 rst = 1'b0;
        #1;
        check("abort_jk_zero", 32'({J, K}), 32'd0);
        check("abort_flags", 32'({busy, done, err, cmd_ready}), 32'd0);
        repeat (3) begin
            @(negedge Clk);
            check("abort_held", 32'({J, K, done}), 32'd0);
        end
        rst = 1'b1;
        @(negedge Clk);
        check("abort_idle_ready", 32'({cmd_ready, busy}), 32'b10);
        repeat (8) begin
            @(negedge Clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_done_count", 32'(done_count - dc), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
